alu_multicycle: RTL and testbench

Parametrised, registered successor to the CPU's 16-bit combinational ALU. It keeps the existing operations and adds logical shift right, AND, OR, and iterative unsigned multiply, divide and modulo. Operation is controlled by a start/busy/done handshake, so the CPU control unit can stall on multi-cycle ops. Flags are extended to N, Z, C and V, plus a divide-by-zero indicator.

---
 rtl/alu_multicycle_if.sv | 28 ++
 rtl/alu_multicycle.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle between the CPU control unit (master)
// and alu_multicycle (slave). clk and rst stay plain ports on the modules.
interface alu_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       ALUop;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUresult;
  logic             flagN;
  logic             flagZ;
  logic             flagC;
  logic             flagV;
  logic             divByZero;

  modport master (
    output start, ALUop, srcA, srcB,
    input  busy, done, ALUresult, flagN, flagZ, flagC, flagV, divByZero
  );

  modport slave (
    input  start, ALUop, srcA, srcB,
    output busy, done, ALUresult, flagN, flagZ, flagC, flagV, divByZero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU. Single-cycle ops (and divide-by-zero / invalid
// ops) finish one cycle after start; MUL/DIV/MOD iterate one bit per cycle
// for WIDTH cycles on a shared hi/lo register pair.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_multicycle_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_SUB  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LSL  = 4'b0010,
    OP_NEG  = 4'b0011,
    OP_PASS = 4'b0100,
    OP_CMP  = 4'b0101,
    OP_LSR  = 4'b0110,
    OP_AND  = 4'b0111,
    OP_OR   = 4'b1000,
    OP_MUL  = 4'b1001,
    OP_DIV  = 4'b1010,
    OP_MOD  = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand for MUL, divisor for DIV/MOD
  logic [WIDTH-1:0] hi_q;     // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;     // multiplier shifting out / quotient shifting in
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] result_q;
  logic             n_q, z_q, c_q, v_q, dbz_q;

  logic [WIDTH-1:0] a, b;
  assign a = bus.srcA;
  assign b = bus.srcB;

  // Single-cycle result straight from the operands being latched this edge.
  logic [WIDTH-1:0] sc_result;
  logic [WIDTH:0]   add_full;
  logic             sc_c, sc_v, sc_dbz, sc_multi;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (that would infer a latch).
    sc_result = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    sc_dbz    = 1'b0;
    sc_multi  = 1'b0;
    add_full  = {1'b0, a} + {1'b0, b};
    case (bus.ALUop)
      OP_SUB: begin
        sc_result = a - b;
        sc_c      = (a >= b);
        sc_v      = (a[MSB] != b[MSB]) && (sc_result[MSB] != a[MSB]);
      end
      OP_ADD: begin
        sc_result = add_full[WIDTH-1:0];
        sc_c      = add_full[WIDTH];
        sc_v      = (a[MSB] == b[MSB]) && (sc_result[MSB] != a[MSB]);
      end
      OP_LSL:  sc_result = (b >= SHIFT_LIM) ? '0 : (a << b);
      OP_NEG:  sc_result = '0 - a;
      OP_PASS: sc_result = a;
      OP_CMP:  sc_result = (a == b) ? '0 : ((a > b) ? WIDTH'(1) : WIDTH'(2));
      OP_LSR:  sc_result = (b >= SHIFT_LIM) ? '0 : (a >> b);
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_MUL:  sc_multi = 1'b1;
      OP_DIV: begin
        if (b == '0) begin
          sc_result = '1;
          sc_dbz    = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
      OP_MOD: begin
        if (b == '0) begin
          sc_result = a;
          sc_dbz    = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
      default: ;  // invalid ops: result 0, flags fall out as Z=1, rest 0
    endcase
  end

  // One shift-add / restoring-divide step from the current hi/lo registers.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] div_rem_nx, div_quo_nx;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_diff[WIDTH]) begin
      div_rem_nx = div_shift[WIDTH-1:0];
      div_quo_nx = {lo_q[WIDTH-2:0], 1'b0};
    end else begin
      div_rem_nx = div_diff[WIDTH-1:0];
      div_quo_nx = {lo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Value published on the edge entering DONE: iterative result on the last
  // EXEC step, otherwise the single-cycle result.
  logic [WIDTH-1:0] fin_result;
  logic             fin_c, fin_v, fin_dbz, publish;

  always_comb begin
    fin_result = sc_result;
    fin_c      = sc_c;
    fin_v      = sc_v;
    fin_dbz    = sc_dbz;
    if (state_q == S_EXEC) begin
      fin_c   = 1'b0;
      fin_v   = 1'b0;
      fin_dbz = 1'b0;
      if (op_q == OP_MUL) begin
        fin_result = mul_lo_nx;
        fin_v      = |mul_hi_nx;
      end else if (op_q == OP_DIV) begin
        fin_result = div_quo_nx;
      end else begin
        fin_result = div_rem_nx;
      end
    end
  end

  assign publish = (state_q == S_EXEC) ? (cnt_q == LAST_ITER)
                                       : (bus.start && !sc_multi);

  // Control FSM plus iteration datapath; start is only honoured outside EXEC.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            op_q  <= bus.ALUop;
            cnt_q <= '0;
            hi_q  <= '0;
            if (sc_multi) begin
              state_q <= S_EXEC;
              busy_q  <= 1'b1;
              if (bus.ALUop == OP_MUL) begin
                opnd_q <= a;
                lo_q   <= b;
              end else begin
                opnd_q <= b;
                lo_q   <= a;
              end
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_EXEC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (op_q == OP_MUL) begin
            hi_q <= mul_hi_nx;
            lo_q <= mul_lo_nx;
          end else begin
            hi_q <= div_rem_nx;
            lo_q <= div_quo_nx;
          end
          if (cnt_q == LAST_ITER) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Result and flags change only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (publish) begin
      result_q <= fin_result;
      n_q      <= fin_result[MSB];
      z_q      <= (fin_result == '0);
      c_q      <= fin_c;
      v_q      <= fin_v;
      dbz_q    <= fin_dbz;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ALUresult = result_q;
  assign bus.flagN     = n_q;
  assign bus.flagZ     = z_q;
  assign bus.flagC     = c_q;
  assign bus.flagV     = v_q;
  assign bus.divByZero = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: a transaction-level reference model
// (plain arithmetic plus a busy countdown) is compared against the DUT every
// cycle, with directed literal checks and a randomized phase.
module tb_alu_multicycle;
  localparam int W = 16;
  localparam int MAXS = 2 ** (W - 1) - 1;
  localparam int MINS = -(2 ** (W - 1));

  typedef struct packed {
    logic [W-1:0] res;
    logic         n, z, c, v, dbz;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_multicycle_if #(.WIDTH(W)) bus ();
  alu_multicycle #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] op, input logic [W-1:0] b);
    return (op == 4'd9) || (((op == 4'd10) || (op == 4'd11)) && (b != '0));
  endfunction

  // Expected result straight from the operation definitions.
  function automatic res_t ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t             r;
    int               sa, sb, sr;
    longint           ua, ub;
    logic [2*W-1:0]   p;
    r  = '0;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      4'd0: begin
        r.res = W'(ua - ub);
        r.c   = (ua >= ub);
        sr    = sa - sb;
        r.v   = (sr > MAXS) || (sr < MINS);
      end
      4'd1: begin
        r.res = W'(ua + ub);
        r.c   = ((ua + ub) >= (longint'(1) << W));
        sr    = sa + sb;
        r.v   = (sr > MAXS) || (sr < MINS);
      end
      4'd2:  r.res = (ub >= W) ? '0 : W'(ua << ub);
      4'd3:  r.res = W'(-ua);
      4'd4:  r.res = a;
      4'd5:  r.res = (ua == ub) ? W'(0) : ((ua > ub) ? W'(1) : W'(2));
      4'd6:  r.res = (ub >= W) ? '0 : W'(ua >> ub);
      4'd7:  r.res = a & b;
      4'd8:  r.res = a | b;
      4'd9: begin
        p     = (2*W)'(ua * ub);
        r.res = p[W-1:0];
        r.v   = (p[2*W-1:W] != '0);
      end
      4'd10: begin
        if (ub == 0) begin r.res = '1; r.dbz = 1'b1; end
        else r.res = W'(ua / ub);
      end
      4'd11: begin
        if (ub == 0) begin r.res = a; r.dbz = 1'b1; end
        else r.res = W'(ua % ub);
      end
      default: r.res = '0;
    endcase
    r.n = r.res[W-1];
    r.z = (r.res == '0);
    return r;
  endfunction

  // Reference model: accepts start when not busy, counts WIDTH busy cycles.
  int   m_busy_left = 0;
  logic m_done = 1'b0;
  res_t m_shown = '0;
  res_t m_pend = '0;
  bit   model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy_left <= 0;
      m_done      <= 1'b0;
      m_shown     <= '0;
      model_on    <= 1'b1;
    end else if (model_on) begin
      if (m_busy_left > 0) begin
        m_busy_left <= m_busy_left - 1;
        m_done      <= (m_busy_left == 1);
        if (m_busy_left == 1) m_shown <= m_pend;
      end else begin
        m_done <= 1'b0;
        if (bus.start) begin
          m_pend <= ref_op(bus.ALUop, bus.srcA, bus.srcB);
          if (is_multi(bus.ALUop, bus.srcB)) begin
            m_busy_left <= W;
          end else begin
            m_done  <= 1'b1;
            m_shown <= ref_op(bus.ALUop, bus.srcA, bus.srcB);
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_on) begin
      check("busy", bus.busy, m_busy_left > 0);
      check("done", bus.done, m_done);
      check("result", bus.ALUresult, m_shown.res);
      check("flagN", bus.flagN, m_shown.n);
      check("flagZ", bus.flagZ, m_shown.z);
      check("flagC", bus.flagC, m_shown.c);
      check("flagV", bus.flagV, m_shown.v);
      check("divByZero", bus.divByZero, m_shown.dbz);
    end
  end

  // Called at a negedge; issues one op and returns at the negedge showing done.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit noise, input string name);
    int lat;
    int exp_lat;
    exp_lat   = is_multi(op, b) ? W + 1 : 1;
    bus.start = 1'b1;
    bus.ALUop = op;
    bus.srcA  = a;
    bus.srcB  = b;
    lat       = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start = (noise && bus.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bus.start) begin
        bus.ALUop = 4'($urandom);
        bus.srcA  = W'($urandom);
        bus.srcB  = W'($urandom);
      end
    end while (!bus.done && lat < 4 * W);
    bus.start = 1'b0;
    check({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] ra, rb;
    bit           saw_done;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.ALUop = '0;
    bus.srcA  = '0;
    bus.srcB  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_result", bus.ALUresult, 0);
    check("reset_flagZ", bus.flagZ, 0);
    check("reset_dbz", bus.divByZero, 0);
    rst = 1'b0;

    // SUB equal operands, then ADD signed overflow.
    do_op(4'd0, W'(5), W'(5), 1'b0, "sub_eq");
    check("sub_eq_result", bus.ALUresult, 0);
    check("sub_eq_Z", bus.flagZ, 1);
    check("sub_eq_C", bus.flagC, 1);
    check("sub_eq_V", bus.flagV, 0);
    do_op(4'd1, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    check("add_ovf_result", bus.ALUresult, 16'h8000);
    check("add_ovf_N", bus.flagN, 1);
    check("add_ovf_Z", bus.flagZ, 0);
    check("add_ovf_C", bus.flagC, 0);
    check("add_ovf_V", bus.flagV, 1);

    // Reset in EXEC cycle 5 of a MUL discards it.
    bus.start = 1'b1;
    bus.ALUop = 4'd9;
    bus.srcA  = 16'h00FF;
    bus.srcB  = 16'h0101;
    @(negedge clk);
    bus.start = 1'b0;
    check("rstmid_busy_pre", bus.busy, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_done", bus.done, 0);
    check("rstmid_result", bus.ALUresult, 0);
    saw_done = 1'b0;
    repeat (3 * W) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("rstmid_no_done", saw_done, 0);

    // MUL with stray start pulses during EXEC.
    do_op(4'd9, 16'h0100, 16'h0100, 1'b1, "mul");
    check("mul_result", bus.ALUresult, 0);
    check("mul_Z", bus.flagZ, 1);
    check("mul_V", bus.flagV, 1);

    // DIV, back-to-back MOD, then divide by zero.
    do_op(4'd10, W'(1000), W'(7), 1'b0, "div");
    check("div_result", bus.ALUresult, 142);
    do_op(4'd11, W'(1000), W'(7), 1'b0, "mod");
    check("mod_result", bus.ALUresult, 6);
    do_op(4'd10, W'(9), W'(0), 1'b0, "div0");
    check("div0_result", bus.ALUresult, 16'hFFFF);
    check("div0_dbz", bus.divByZero, 1);
    check("div0_C", bus.flagC, 0);
    check("div0_V", bus.flagV, 0);

    // Shifts, compare, negate.
    do_op(4'd2, 16'h0003, W'(16), 1'b0, "lsl16");
    check("lsl16_result", bus.ALUresult, 0);
    check("lsl16_Z", bus.flagZ, 1);
    do_op(4'd6, 16'h8000, W'(15), 1'b0, "lsr15");
    check("lsr15_result", bus.ALUresult, 16'h0001);
    do_op(4'd5, W'(3), W'(9), 1'b0, "cmp_lt");
    check("cmp_lt_result", bus.ALUresult, 2);
    do_op(4'd3, 16'h0001, W'(0), 1'b0, "neg1");
    check("neg1_result", bus.ALUresult, 16'hFFFF);
    check("neg1_N", bus.flagN, 1);

    // Invalid op, then hold across idle cycles.
    do_op(4'b1110, 16'h1234, 16'h4321, 1'b0, "invalid");
    check("invalid_result", bus.ALUresult, 0);
    check("invalid_Z", bus.flagZ, 1);
    check("invalid_N", bus.flagN, 0);
    check("invalid_C", bus.flagC, 0);
    check("invalid_V", bus.flagV, 0);
    repeat (10) @(negedge clk);
    check("hold_result", bus.ALUresult, 0);
    check("hold_Z", bus.flagZ, 1);

    // Randomized ops, mixed back-to-back and idle gaps.
    for (int i = 0; i < 250; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(0, W + 2));
        default: rb = W'($urandom);
      endcase
      do_op(op, ra, rb, 1'($urandom_range(0, 1)), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
